// File: rtl/dadda_mult_arbiter_if.sv
// dadda_mult_arbiter_if: request/response bundle between clients and the shared multiplier arbiter
interface dadda_mult_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4,
    parameter int IDW   = $clog2(NREQ)
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [2*WIDTH-1:0]    rsp_prod;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_prod
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_prod
    );
endinterface

// File: rtl/dadda_mult_arbiter.sv
// dadda_mult_arbiter: round-robin sharing of one combinational multiplier among NREQ requesters,
// holding operands for MUL_LAT cycles and returning an ID-tagged product over valid/ready.
module dadda_mult_arbiter #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 4,
    parameter int MUL_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    dadda_mult_arbiter_if.slave bus,
    output logic [WIDTH-1:0]   mul_in1_o,
    output logic [WIDTH-1:0]   mul_in2_o,
    input  logic [WIDTH-1:0]   mul_out_i,
    input  logic [WIDTH-1:0]   mul_ovf_i,
    output logic               busy_o,
    output logic [CNT_W-1:0]   done_cnt_o
);
    localparam int IDW = $clog2(NREQ);
    localparam int WW  = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t             state_q, state_d;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [IDW-1:0]     id_q, id_d;
    logic [WW-1:0]      wait_q, wait_d;
    logic [WIDTH-1:0]   in1_q, in1_d;
    logic [WIDTH-1:0]   in2_q, in2_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]     rsp_id_q, rsp_id_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [WIDTH-1:0]   op_a [NREQ];
    logic [WIDTH-1:0]   op_b [NREQ];
    logic [IDW-1:0]     grant;
    logic [IDW-1:0]     idx;
    logic               found;

    for (genvar i = 0; i < NREQ; i++) begin : g_op
        assign op_a[i] = bus.req_a[i*WIDTH +: WIDTH];
        assign op_b[i] = bus.req_b[i*WIDTH +: WIDTH];
    end

    // Scan from the farthest offset down so the nearest valid requester after rr_ptr wins last.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int o = NREQ - 1; o >= 0; o--) begin
            idx = IDW'((int'(ptr_q) + o) % NREQ);
            if (bus.req_valid[idx]) begin
                found = 1'b1;
                grant = idx;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        wait_d      = wait_q;
        in1_d       = in1_q;
        in2_d       = in2_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        prod_d      = prod_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: if (found) begin
                in1_d   = op_a[grant];
                in2_d   = op_b[grant];
                id_d    = grant;
                ptr_d   = (grant == IDW'(NREQ - 1)) ? '0 : grant + 1'b1;
                wait_d  = WW'(MUL_LAT - 1);
                state_d = ISSUE;
            end
            ISSUE: if (wait_q == '0) begin
                prod_d      = {mul_ovf_i, mul_out_i};
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                cnt_d       = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
                state_d     = RESP;
            end else begin
                wait_d = wait_q - 1'b1;
            end
            RESP: if (bus.rsp_ready) begin
                rsp_valid_d = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            id_q        <= '0;
            wait_q      <= '0;
            in1_q       <= '0;
            in2_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            prod_q      <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            wait_q      <= wait_d;
            in1_q       <= in1_d;
            in2_q       <= in2_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            prod_q      <= prod_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.req_ready = (state_q == IDLE && found) ? NREQ'(1) << grant : '0;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_prod  = prod_q;
    assign mul_in1_o     = in1_q;
    assign mul_in2_o     = in2_q;
    assign busy_o        = state_q != IDLE;
    assign done_cnt_o    = cnt_q;
endmodule

// File: tb/tb_dadda_mult_arbiter.sv
// tb_dadda_mult_arbiter: two arbiters (MUL_LAT 1 and 3) with exact multipliers, checked
// every cycle against a transaction-level model, plus directed scenarios.
module tb_dadda_mult_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    logic        dir_en = 1'b1;
    logic [3:0]  dir_v = '0;
    logic [15:0] dir_a = '0;
    logic [15:0] dir_b = '0;
    logic        dir_rdy = 1'b1;

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int pick(input logic [3:0] v, input int p);
        for (int o = 0; o < 4; o++)
            if (v[2'((p + o) % 4)]) return (p + o) % 4;
        return -1;
    endfunction

    for (genvar k = 0; k < 2; k++) begin : g_lane
        localparam int LAT = (k == 0) ? 1 : 3;
        dadda_mult_arbiter_if #(.NREQ(4), .WIDTH(4)) bus();
        logic [3:0]  in1, in2, mo, mv;
        logic        busy;
        logic [15:0] done_cnt;
        logic [3:0]  rv = '0;
        logic [3:0]  acc = '0;
        logic [15:0] ra = '0;
        logic [15:0] rb = '0;
        logic        rr = 1'b1;
        bit          free = 1'b1;
        int          cyc = 0, rsp_at = 0, ptr = 0, done = 0, m_id = 0, m_a = 0, m_b = 0;
        int          g_acc, g_chk;
        bit          exp_rv;

        assign {mv, mo} = 8'(in1) * 8'(in2);
        assign bus.req_valid = dir_en ? dir_v : rv;
        assign bus.req_a     = dir_en ? dir_a : ra;
        assign bus.req_b     = dir_en ? dir_b : rb;
        assign bus.rsp_ready = dir_en ? dir_rdy : rr;

        dadda_mult_arbiter #(.NREQ(4), .WIDTH(4), .MUL_LAT(LAT), .CNT_W(16)) dut (
            .clk(clk), .rst_n(rst_n), .bus(bus),
            .mul_in1_o(in1), .mul_in2_o(in2), .mul_out_i(mo), .mul_ovf_i(mv),
            .busy_o(busy), .done_cnt_o(done_cnt)
        );

        // Requesters keep a request up until the model says it was accepted.
        always @(posedge clk) begin
            #1;
            for (int i = 0; i < 4; i++)
                if (!rv[i] || acc[i]) begin
                    rv[i] = ($urandom % 3) != 0;
                    ra[i*4 +: 4] = 4'($urandom);
                    rb[i*4 +: 4] = 4'($urandom);
                end
            rr = ($urandom % 4) != 0;
        end

        // Transaction model: one op in flight, response due LAT+1 cycles after accept.
        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                free = 1'b1;
                ptr  = 0;
                done = 0;
                acc  = '0;
                cyc  = 0;
            end else begin
                acc = '0;
                if (free) begin
                    g_acc = pick(bus.req_valid, ptr);
                    if (g_acc >= 0) begin
                        free   = 1'b0;
                        m_id   = g_acc;
                        m_a    = int'(bus.req_a >> (4 * g_acc)) & 15;
                        m_b    = int'(bus.req_b >> (4 * g_acc)) & 15;
                        rsp_at = cyc + LAT + 1;
                        ptr    = (g_acc + 1) % 4;
                        acc    = 4'(1 << g_acc);
                    end
                end else if (cyc >= rsp_at && bus.rsp_ready) begin
                    free = 1'b1;
                end
                if (!free && cyc + 1 == rsp_at) done = (done < 65535) ? done + 1 : done;
                cyc++;
            end
        end

        always @(negedge clk) begin
            if (rst_n) begin
                g_chk  = pick(bus.req_valid, ptr);
                exp_rv = !free && cyc >= rsp_at;
                check($sformatf("L%0d req_ready", LAT), bus.req_ready,
                      (free && g_chk >= 0) ? (1 << g_chk) : 0);
                check($sformatf("L%0d busy", LAT), busy, !free);
                check($sformatf("L%0d rsp_valid", LAT), bus.rsp_valid, exp_rv);
                check($sformatf("L%0d done_cnt", LAT), done_cnt, done);
                if (exp_rv) begin
                    check($sformatf("L%0d rsp_id", LAT), bus.rsp_id, m_id);
                    check($sformatf("L%0d rsp_prod", LAT), bus.rsp_prod, m_a * m_b);
                end
                if (!free) begin
                    check($sformatf("L%0d mul_in1", LAT), in1, m_a);
                    check($sformatf("L%0d mul_in2", LAT), in2, m_b);
                end
            end
        end
    end

    task automatic cyc_wait(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        check({tag, " busy0"}, g_lane[0].busy, 0);
        check({tag, " busy1"}, g_lane[1].busy, 0);
        check({tag, " rsp_valid"}, g_lane[0].bus.rsp_valid, 0);
        check({tag, " req_ready"}, g_lane[0].bus.req_ready, 0);
        check({tag, " mul_in1"}, g_lane[0].in1, 0);
        check({tag, " mul_in2"}, g_lane[0].in2, 0);
        check({tag, " rsp_id"}, g_lane[0].bus.rsp_id, 0);
        check({tag, " rsp_prod"}, g_lane[0].bus.rsp_prod, 0);
        check({tag, " done_cnt"}, g_lane[0].done_cnt, 0);
    endtask

    initial begin
        cyc_wait(3);
        check_reset("por");
        rst_n = 1'b1;
        cyc_wait(2);

        dir_v = 4'b0001; dir_a = 16'h0002; dir_b = 16'h0003;
        cyc_wait(1);
        dir_v = '0;
        check("t1 ready low", g_lane[0].bus.rsp_valid, 0);
        cyc_wait(1);
        check("t1 rsp_valid", g_lane[0].bus.rsp_valid, 1);
        check("t1 rsp_prod", g_lane[0].bus.rsp_prod, 6);
        check("t1 done_cnt", g_lane[0].done_cnt, 1);
        cyc_wait(8);

        dir_v = 4'b1111; dir_a = 16'h4321; dir_b = 16'h2222;
        cyc_wait(16);
        dir_v = '0;
        cyc_wait(10);

        dir_v = 4'b1001; dir_a = 16'h5007; dir_b = 16'h3002;
        cyc_wait(14);
        dir_v = '0;
        cyc_wait(10);

        dir_rdy = 1'b0; dir_v = 4'b0001; dir_a = 16'h000F; dir_b = 16'h000F;
        cyc_wait(1);
        dir_v = '0;
        cyc_wait(6);
        check("t4 rsp_valid", g_lane[0].bus.rsp_valid, 1);
        check("t4 rsp_prod", g_lane[0].bus.rsp_prod, 225);
        check("t4 req_ready", g_lane[0].bus.req_ready, 0);
        dir_rdy = 1'b1;
        cyc_wait(8);

        dir_v = 4'b0010; dir_a = 16'h0070; dir_b = 16'h0090;
        cyc_wait(1);
        dir_v = '0;
        cyc_wait(2);
        check("t5 rsp early", g_lane[1].bus.rsp_valid, 0);
        check("t5 in1 held", g_lane[1].in1, 7);
        cyc_wait(1);
        check("t5 rsp_valid", g_lane[1].bus.rsp_valid, 1);
        check("t5 rsp_prod", g_lane[1].bus.rsp_prod, 63);
        check("t5 rsp_id", g_lane[1].bus.rsp_id, 1);
        cyc_wait(8);

        dir_v = 4'b0001; dir_a = 16'h0005; dir_b = 16'h0006;
        cyc_wait(1);
        dir_v = '0;
        #1 rst_n = 1'b0;
        #1 check_reset("t6");
        dir_v = 4'b1010; dir_a = 16'h0304; dir_b = 16'h0102;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("t6 grant0", g_lane[0].bus.req_ready, 4'b0010);
        check("t6 grant1", g_lane[1].bus.req_ready, 4'b0010);
        cyc_wait(1);
        dir_v = '0;
        cyc_wait(8);

        dir_en = 1'b0;
        cyc_wait(3000);
        dir_en = 1'b1;
        dir_v = '0;
        dir_rdy = 1'b1;
        cyc_wait(10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
